// File: rtl/apb_master.sv
// APB initiator: accepts one command at a time on a valid/ready port, runs the
// SETUP/ACCESS handshake toward a decoded slave and returns a one-cycle response.
module apb_master #(
   parameter int unsigned NUM_SLAVES = 4,
   parameter int unsigned SEL_LSB    = 12,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                       PCLK,
   input  logic                       PRESETn,
   // command / response side
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_write,
   input  logic [31:0]                cmd_addr,
   input  logic [31:0]                cmd_wdata,
   output logic                       rsp_valid,
   output logic [31:0]                rsp_rdata,
   output logic                       rsp_err,
   // APB side
   output logic [31:0]                PADDR,
   output logic [NUM_SLAVES-1:0]      PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   output logic [31:0]                PWDATA,
   input  logic [32*NUM_SLAVES-1:0]   PRDATA,
   input  logic [NUM_SLAVES-1:0]      PREADY,
   input  logic [NUM_SLAVES-1:0]      PSLVERR
);

   // A single slave still needs a 1-bit index register; it is simply held at 0.
   localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess
   } state_e;

   state_e                  state;
   logic [IDX_W-1:0]        idx;
   logic [31:0]             cnt;

   logic [IDX_W-1:0]        cmd_idx;
   logic                    cmd_idx_ok;
   logic [NUM_SLAVES-1:0]   sel_dec;
   logic                    sel_ready;
   logic                    sel_err;
   logic [31:0]             sel_rdata;

   // Slave index field of the incoming address.
   if (NUM_SLAVES == 1) begin : g_one_slave
      assign cmd_idx = '0;
   end else begin : g_many_slaves
      assign cmd_idx = cmd_addr[SEL_LSB +: IDX_W];
   end

   // Non-power-of-two slave counts leave unused index codes; those are decode errors.
   assign cmd_idx_ok = (32'(cmd_idx) < NUM_SLAVES);

   // One-hot select for the incoming command's slave.
   always_comb begin
      sel_dec = '0;
      for (int k = 0; k < int'(NUM_SLAVES); k++) begin
         if (32'(cmd_idx) == 32'(k)) sel_dec[k] = 1'b1;
      end
   end

   // Return path from the slave owning the current transfer.
   assign sel_ready = PREADY[idx];
   assign sel_err   = PSLVERR[idx];
   assign sel_rdata = PRDATA[idx*32 +: 32];

   // Ready only while idle; the response cycle is idle so back-to-back accepts work.
   assign cmd_ready = (state == StIdle);

   // Transfer sequencer with registered APB and response outputs.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state     <= StIdle;
         idx       <= '0;
         cnt       <= '0;
         PSEL      <= '0;
         PENABLE   <= 1'b0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            StIdle: begin
               if (cmd_valid) begin
                  PADDR  <= cmd_addr;
                  PWRITE <= cmd_write;
                  PWDATA <= cmd_wdata;
                  if (cmd_idx_ok) begin
                     idx   <= cmd_idx;
                     PSEL  <= sel_dec;
                     cnt   <= '0;
                     state <= StSetup;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end
               end
            end
            StSetup: begin
               PENABLE <= 1'b1;
               state   <= StAccess;
            end
            StAccess: begin
               if (sel_ready) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= sel_err;
                  rsp_rdata <= (!PWRITE && !sel_err) ? sel_rdata : 32'd0;
                  PSEL      <= '0;
                  PENABLE   <= 1'b0;
                  state     <= StIdle;
               end else begin
                  cnt <= cnt + 32'd1;
                  // Abort after TIMEOUT consecutive not-ready ACCESS cycles.
                  if ((TIMEOUT != 0) && (cnt + 32'd1 == TIMEOUT)) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     PSEL      <= '0;
                     PENABLE   <= 1'b0;
                     state     <= StIdle;
                  end
               end
            end
            default: begin
               PSEL    <= '0;
               PENABLE <= 1'b0;
               state   <= StIdle;
            end
         endcase
      end
   end

endmodule
